// File: rtl/cursor_y_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_y_ctrl
//  Description : Vertical palette-cursor controller. Synchronizes two
//                asynchronous button levels, detects presses, and plays a
//                short sub-row animation on the Y-offset datapath (C = 1,2,3,
//                each held HOLD cycles). It then commits the new row, with
//                wrap-around at the top and bottom rows.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ROW_MAX  : highest legal row (rows 0..ROW_MAX, ROW_MAX <= 63)
//    HOLD     : cycles each animation sub-step is held (1..255)
//  Ports
//    clk      : in  - clock, all state changes on rising edge
//    rst      : in  - asynchronous active-low reset
//    enable   : in  - palette cursor active
//    btn_up   : in  - async button level, move to lower row
//    btn_down : in  - async button level, move to higher row
//    in_y     : out - committed row [5:0]
//    plus     : out - datapath load strobe
//    sum      : out - 1 = add C, 0 = subtract C
//    C        : out - sub-row pixel offset [2:0]
//    busy     : out - high whenever the FSM is not idle
//    moved    : out - one-cycle pulse when a new row is committed
// ============================================================================
module cursor_y_ctrl #(
    parameter int ROW_MAX = 15,
    parameter int HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [5:0] in_y,
    output logic       plus,
    output logic       sum,
    output logic [2:0] C,
    output logic       busy,
    output logic       moved
);

    localparam logic [5:0] ROW_MAX_Y = 6'(ROW_MAX);
    localparam logic [7:0] HOLD_RLD  = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        COMMIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizers and press detection
    // ------------------------------------------------------------------
    logic up_meta_q, up_sync_q, up_prev_q;
    logic dn_meta_q, dn_sync_q, dn_prev_q;
    logic vld1_q, vld2_q;
    logic up_press, dn_press;

    // The sync chain holds reset zeros for two cycles, which do not reflect
    // the real button. The history flops are kept at 1 until the chain holds
    // genuine samples, so a button held across reset must first be seen low
    // before it can produce a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_meta_q <= 1'b0;
            up_sync_q <= 1'b0;
            up_prev_q <= 1'b1;
            dn_meta_q <= 1'b0;
            dn_sync_q <= 1'b0;
            dn_prev_q <= 1'b1;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
        end else begin
            up_meta_q <= btn_up;
            up_sync_q <= up_meta_q;
            dn_meta_q <= btn_down;
            dn_sync_q <= dn_meta_q;
            vld1_q    <= 1'b1;
            vld2_q    <= vld1_q;
            up_prev_q <= vld2_q ? up_sync_q : 1'b1;
            dn_prev_q <= vld2_q ? dn_sync_q : 1'b1;
        end
    end

    assign up_press = up_sync_q & ~up_prev_q;
    assign dn_press = dn_sync_q & ~dn_prev_q;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [5:0] in_y_q;
    logic       plus_q;
    logic       sum_q;
    logic [2:0] c_q;
    logic       busy_q;
    logic       moved_q;
    logic [7:0] hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            in_y_q  <= 6'd0;
            plus_q  <= 1'b0;
            sum_q   <= 1'b0;
            c_q     <= 3'd0;
            busy_q  <= 1'b0;
            moved_q <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    plus_q <= 1'b0;
                    c_q    <= 3'd0;
                    if (enable && up_press && dn_press) begin
                        // Conflicting presses: swallow them and wait for release.
                        state_q <= RELEASE;
                        busy_q  <= 1'b1;
                    end else if (enable && (up_press ^ dn_press)) begin
                        sum_q  <= dn_press;
                        busy_q <= 1'b1;
                        plus_q <= 1'b1;
                        if (dn_press && (in_y_q == ROW_MAX_Y)) begin
                            // Wrap jumps straight to the new row, no animation.
                            state_q <= COMMIT;
                            in_y_q  <= 6'd0;
                            moved_q <= 1'b1;
                        end else if (up_press && (in_y_q == 6'd0)) begin
                            state_q <= COMMIT;
                            in_y_q  <= ROW_MAX_Y;
                            moved_q <= 1'b1;
                        end else begin
                            state_q <= STEP;
                            c_q     <= 3'd1;
                            hold_q  <= HOLD_RLD;
                        end
                    end
                end

                STEP: begin
                    if (!enable) begin
                        // Abort: C=0 with the old row restores the datapath to 4*in_y.
                        state_q <= COMMIT;
                        c_q     <= 3'd0;
                    end else if (hold_q != 8'd0) begin
                        hold_q <= hold_q - 8'd1;
                    end else if (c_q == 3'd3) begin
                        state_q <= COMMIT;
                        c_q     <= 3'd0;
                        moved_q <= 1'b1;
                        in_y_q  <= sum_q ? (in_y_q + 6'd1) : (in_y_q - 6'd1);
                    end else begin
                        c_q    <= c_q + 3'd1;
                        hold_q <= HOLD_RLD;
                    end
                end

                COMMIT: begin
                    state_q <= RELEASE;
                    plus_q  <= 1'b0;
                end

                RELEASE: begin
                    // No auto-repeat: both buttons must be let go first.
                    if (!up_sync_q && !dn_sync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    plus_q  <= 1'b0;
                    c_q     <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_y  = in_y_q;
    assign plus  = plus_q;
    assign sum   = sum_q;
    assign C     = c_q;
    assign busy  = busy_q;
    assign moved = moved_q;

endmodule
`default_nettype wire
